// File: rtl/tt_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : tt_bank_loader
// Summary  : Host-side writer for a TinyTapeout dual-bank (2 x 5-bit) register
//            design. Drives strobe/clr/sel/data on the target io_in pins
//            (bank A first, then bank B, or a single clear pulse). It then
//            samples the target result and readback pins through
//            2-flop synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
module tt_bank_loader #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic [9:0] word_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       result_o,
  output logic       rb_err_o,
  output logic [7:0] tgt_in_o,
  input  logic [7:0] tgt_out_i
);

  // One shared phase counter, sized for the longest phase (loaded with N-1).
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HS  = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HS) ? MAX_SP : MAX_HS;
  localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SETUP_A = 4'd1,
    PULSE_A = 4'd2,
    HOLD_A  = 4'd3,
    SETUP_B = 4'd4,
    PULSE_B = 4'd5,
    HOLD_B  = 4'd6,
    SETTLE  = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [9:0]       word_q, word_d;
  logic             op_clr, op_clr_d;
  logic             last;
  logic             sample;
  logic [7:0]       pins_d;
  logic             busy_d;
  logic             done_d;
  logic [2:0]       sync1, sync2;

  // Only io_out[0], [3] and [7] carry information for this loader.
  logic unused_pins;
  assign unused_pins = ^{tgt_out_i[6:4], tgt_out_i[2:1]};

  assign last = (cnt == '0);

  // State, counter, latched request and registered pin/status outputs.
  // Pins are registered from the next-state decode so they never glitch and
  // have no combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      word_q   <= '0;
      op_clr   <= 1'b0;
      tgt_in_o <= 8'h00;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      word_q   <= word_d;
      op_clr   <= op_clr_d;
      tgt_in_o <= pins_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
    end
  end

  // Next-state, counter and pin decode for the load/clear sequencer.
  always_comb begin
    state_d  = state;
    cnt_d    = last ? '0 : cnt - 1'b1;
    word_d   = word_q;
    op_clr_d = op_clr;
    sample   = 1'b0;

    case (state)
      IDLE: begin
        // Clear has priority; a clear loads zero data so data pins stay 0.
        if (clear_i) begin
          state_d  = SETUP_A;
          cnt_d    = SETUP_LD;
          word_d   = 10'd0;
          op_clr_d = 1'b1;
        end else if (start_i) begin
          state_d  = SETUP_A;
          cnt_d    = SETUP_LD;
          word_d   = word_i;
          op_clr_d = 1'b0;
        end
      end
      SETUP_A: if (last) begin state_d = PULSE_A; cnt_d = PULSE_LD; end
      PULSE_A: if (last) begin state_d = HOLD_A;  cnt_d = HOLD_LD;  end
      HOLD_A: begin
        if (last) begin
          if (op_clr) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = SETUP_B;
            cnt_d   = SETUP_LD;
          end
        end
      end
      SETUP_B: if (last) begin state_d = PULSE_B; cnt_d = PULSE_LD;  end
      PULSE_B: if (last) begin state_d = HOLD_B;  cnt_d = HOLD_LD;   end
      HOLD_B:  if (last) begin state_d = SETTLE;  cnt_d = SETTLE_LD; end
      SETTLE: begin
        if (last) begin
          state_d = DONE;
          sample  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin map: [7:3]=data, [2]=sel, [1]=clr, [0]=strobe.
    pins_d = 8'h00;
    case (state_d)
      SETUP_A, HOLD_A: pins_d = {word_d[4:0], 1'b0, op_clr_d, 1'b0};
      PULSE_A:         pins_d = {word_d[4:0], 1'b0, op_clr_d, 1'b1};
      SETUP_B, HOLD_B: pins_d = {word_d[9:5], 1'b1, 1'b0, 1'b0};
      PULSE_B:         pins_d = {word_d[9:5], 1'b1, 1'b0, 1'b1};
      default:         pins_d = 8'h00;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // Two-flop synchronizer for result, readback and link-check pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {tgt_out_i[7], tgt_out_i[3], tgt_out_i[0]};
      sync2 <= sync1;
    end
  end

  // Capture result and readback status at the end of SETTLE; held until the
  // next completion. io_out[7] mirrors ~strobe, so it must read 1 here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_o <= 1'b0;
      rb_err_o <= 1'b0;
    end else if (sample) begin
      result_o <= sync2[0];
      rb_err_o <= (sync2[1] != word_q[9]) | (sync2[2] != 1'b1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_bank_loader
// Summary  : Self-checking bench for tt_bank_loader with a behavioural model
//            of the dual-bank target (popcount>=5 result, bank B bit 4
//            readback on io_out[3], ~strobe on io_out[7]).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_bank_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       clear_i;
  logic [9:0] word_i;
  logic       busy_o;
  logic       done_o;
  logic       result_o;
  logic       rb_err_o;
  logic [7:0] tgt_in_o;
  logic [7:0] tgt_out_i;

  int n_cmp = 0;
  int n_bad = 0;

  tt_bank_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .clear_i   (clear_i),
    .word_i    (word_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .rb_err_o  (rb_err_o),
    .tgt_in_o  (tgt_in_o),
    .tgt_out_i (tgt_out_i)
  );

  always #5 clk = ~clk;

  // Target model: banks clock on the strobe rising edge.
  logic [4:0] bank_a = 5'd0;
  logic [4:0] bank_b = 5'd0;
  logic       stuck3 = 1'b0;
  logic       stuck7 = 1'b0;

  // Target register update on strobe rise.
  always @(posedge tgt_in_o[0]) begin
    if (tgt_in_o[1]) begin
      bank_a <= 5'd0;
      bank_b <= 5'd0;
    end else if (tgt_in_o[2]) begin
      bank_b <= tgt_in_o[7:3];
    end else begin
      bank_a <= tgt_in_o[7:3];
    end
  end

  assign tgt_out_i = {stuck7 ? 1'b0 : ~tgt_in_o[0], 3'b000,
                      stuck3 ? 1'b0 : bank_b[4], 2'b00,
                      ($countones({bank_b, bank_a}) >= 5)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: sel/data/clr may only change while strobe is 0 before and after.
  logic [7:0] prev_pins = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pins = 8'h00;
    end else begin
      n_cmp++;
      if ((tgt_in_o[7:1] != prev_pins[7:1]) && (tgt_in_o[0] || prev_pins[0])) begin
        n_bad++;
        $display("FAIL pin_stability: pins %0h -> %0h while strobe high (t=%0t)",
                 prev_pins, tgt_in_o, $time);
      end
      prev_pins = tgt_in_o;
    end
  end

  // op: 0 = load, 1 = clear, 2 = load and clear together.
  // exp_lat = edges after the accepting edge E0 until done_o is seen, i.e.
  // done_o is high in the cycle closed by edge exp_lat+1.
  typedef struct {
    logic [1:0] op;
    logic [9:0] word;
    logic       s3;
    logic       s7;
    int         exp_pulses;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         exp_lat;
    logic       exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_op(input vec_t v, input logic chk_prev, input logic prev_res);
    int   n;
    int   pulses;
    logic got;
    logic ps;
    logic busy_gap;
    logic [7:0] a_pins;
    logic [7:0] b_pins;
    stuck3 = v.s3;
    stuck7 = v.s7;
    @(negedge clk);
    word_i  = v.word;
    start_i = (v.op != 2'd1);
    clear_i = (v.op != 2'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    check("busy_after_accept", busy_o, 1'b1);
    if (chk_prev) check("result_held", result_o, prev_res);
    n = 0; pulses = 0; got = 1'b0; ps = 1'b0; busy_gap = 1'b0;
    a_pins = 8'h00; b_pins = 8'h00;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (tgt_in_o[0] && !ps) begin
        pulses++;
        if (pulses == 1) a_pins = tgt_in_o;
        if (pulses == 2) b_pins = tgt_in_o;
      end
      ps = tgt_in_o[0];
      if (done_o) got = 1'b1;
      else if (!busy_o) busy_gap = 1'b1;
    end
    check("done_seen", got, 1'b1);
    check("latency", n, v.exp_lat);
    check("busy_continuous", busy_gap, 1'b0);
    check("strobe_count", pulses, v.exp_pulses);
    check("pins_pulse_a", a_pins, v.exp_a);
    if (v.exp_pulses == 2) check("pins_pulse_b", b_pins, v.exp_b);
    check("busy_in_done", busy_o, 1'b0);
    check("result", result_o, v.exp_res);
    check("rb_err", rb_err_o, v.exp_err);
    if (v.op != 2'd0) check("model_banks_zero", {bank_b, bank_a}, 10'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done_o, 1'b0);
    check("pins_idle", tgt_in_o, 8'h00);
  endtask

  initial begin
    int n;
    int pulses;
    int dones;
    logic ps;

    //          op    word     s3    s7   np  A      B      lat res   err
    vecs[0] = '{2'd0, 10'h3FF, 1'b0, 1'b0, 2, 8'hF9, 8'hFD, 14, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 10'h000, 1'b0, 1'b0, 1, 8'h03, 8'h00,  9, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 10'h155, 1'b0, 1'b0, 1, 8'h03, 8'h00,  9, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 10'h200, 1'b1, 1'b0, 2, 8'h01, 8'h85, 14, 1'b0, 1'b1};
    vecs[4] = '{2'd0, 10'h200, 1'b0, 1'b1, 2, 8'h01, 8'h85, 14, 1'b0, 1'b1};
    vecs[5] = '{2'd0, 10'h0F5, 1'b0, 1'b0, 2, 8'hA9, 8'h3D, 14, 1'b1, 1'b0};
    vecs[6] = '{2'd0, 10'h021, 1'b0, 1'b0, 2, 8'h09, 8'h0D, 14, 1'b0, 1'b0};

    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; word_i = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_pins", tgt_in_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_result", result_o, 1'b0);
    check("rst_rberr", rb_err_o, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i], (i > 0), (i > 0) ? vecs[(i > 0) ? i - 1 : 0].exp_res : 1'b0);

    // Requests while busy (and in the DONE cycle) are dropped.
    stuck3 = 1'b0; stuck7 = 1'b0;
    @(negedge clk);
    word_i = 10'h3FF; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    pulses = 0; dones = 0; ps = 1'b0;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0; clear_i = 1'b0;
      if (tgt_in_o[0] && !ps) pulses++;
      ps = tgt_in_o[0];
      if (done_o) dones++;
      if (n == 3 || n == 8 || done_o) start_i = 1'b1;
      if (n == 8) clear_i = 1'b1;
    end
    start_i = 1'b0; clear_i = 1'b0;
    check("busy_ignore_pulses", pulses, 2);
    check("busy_ignore_dones", dones, 1);
    check("busy_ignore_idle", busy_o, 1'b0);

    // Asynchronous reset in the middle of PULSE_B.
    @(negedge clk);
    word_i = 10'h3FF; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pulse_b_before_rst", tgt_in_o, 8'hFD);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pins", tgt_in_o, 8'h00);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_result", result_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[1], 1'b0, 1'b0);
    run_op(vecs[0], 1'b1, vecs[1].exp_res);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
